operand_fetch: RTL and testbench
================================

# operand_fetch

Pipeline stage directly upstream of `alu`. It accepts a decoded instruction and its PC, reads rs1/rs2 from the integer register file it owns, and presents `instruction`, `op_a` and `op_b` to the ALU through a one-entry registered output. It also takes the writeback port that updates the register file, with optional write-to-read forwarding.

## Interface
- `XLEN`, 32, data and register width.
- `RESET_PC_VAL`, 32'h0000_0000, reset value of the `pc` output.
- `clk`  in  1  clock; every register is updated on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  upstream offers an instruction.
- `in_ready`  out  1  the stage can accept this cycle.
- `in_instruction`  in  32  raw RV32I instruction.
- `in_pc`  in  XLEN  PC of `in_instruction`.
- `out_valid`  out  1  `instruction`, `pc`, `op_a` and `op_b` are valid.
- `out_ready`  in  1  the ALU side consumes this cycle.
- `instruction`  out  32  registered copy of the accepted instruction.
- `pc`  out  XLEN  registered PC.
- `op_a`  out  XLEN  first operand.
- `op_b`  out  XLEN  second operand.
- `wb_en`  in  1  register-file write strobe.
- `wb_rd`  in  5  write index.
- `wb_data`  in  XLEN  write data.

## Operation
- Register file: x1..x31, each XLEN bits. x0 reads 0. Writes with `wb_rd`=0 are ignored.
- Field extraction: rs1 = `in_instruction[19:15]`, rs2 = `in_instruction[24:20]`.
- Operand select:
  - `op_a`: `in_pc` when the opcode is `OPCODE_AUIPC`, `OPCODE_JAL` or `OPCODE_BRANCH`; 0 for `OPCODE_LUI`; otherwise rs1 value.
  - `op_b`: always the rs2 value, including immediate forms. The ALU takes immediates from `instruction` and ignores `op_b` there.
- Handshake:
  - `in_ready = !out_valid || out_ready`.
  - Accept when `in_valid && in_ready`. On accept, capture all four outputs and set `out_valid`=1.
  - Consume when `out_valid && out_ready`. If a consume happens without a simultaneous accept, clear `out_valid`.
  - While `out_valid && !out_ready`, outputs hold stable, subject only to forwarding (below).
- State:
  - EMPTY (`out_valid`=0): accept → FULL.
  - FULL: consume with no accept → EMPTY; consume with accept → FULL with the new data; no consume → FULL, held.
- Writeback: on `wb_en`, `regs[wb_rd] <= wb_data` at the edge. The write is independent of the handshake.
- Arithmetic: no arithmetic; all paths are XLEN wide with no extension.

## Timing
- Latency: an instruction accepted at edge N appears with `out_valid`=1 after edge N. Throughput is one per cycle while `out_ready`=1.
- Reset (any cycle, including mid-transfer):
  - `out_valid`=0; `instruction`=32'h0; `pc`=`RESET_PC_VAL`; `op_a`=`op_b`=0.
  - All registers cleared to 0.
  - `wb_en` and `in_valid` are ignored in that cycle.
  - `in_ready`=1 in the first cycle after reset.
- Simultaneous writeback and read of the same register (without forwarding): the read returns the pre-write value.
- Back-to-back accept while FULL with `out_ready`=1: no bubble.

## Configuration
- `OPERAND_BYPASS_EN` defined:
  - Forwarding on accept: if `wb_en`, `wb_rd`≠0 and `wb_rd` equals rs1/rs2 on the accept cycle, the corresponding operand captures `wb_data`.
  - Forwarding while held: while FULL and not consumed, a matching writeback replaces held `op_a`/`op_b`. `op_a` is replaced only when it was sourced from rs1.
  - Implementation: the held rs1/rs2 indices and the op_a-source flag are kept in registers.
- Undefined: no forwarding. The upstream must stall for RAW hazards.

## Structure
- Constants come from the shared `params.vh`: `OPCODE_*` and `FUNCT3_*`. Add field-position constants for rs1, rs2 and rd there.
- Sub-module: `register_file` (31×XLEN, combinational dual read, one synchronous write, synchronous clear). Forwarding and output staging live in `operand_fetch`.

## Test plan
- Reset, then write x5=32'h1234_5678. Accept `add x1,x5,x0` → next cycle `out_valid`=1, `op_a`=32'h1234_5678, `op_b`=0.
- Accept `auipc` with `in_pc`=32'h0000_0100 → `op_a`=32'h0000_0100. Accept `lui` → `op_a`=0.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, outputs stable. Raise `out_ready` → the next instruction appears the following cycle with no loss or duplication.
- Write `wb_rd`=0, `wb_data`=32'hdead_beef, then read x0 → operand = 0.
- Same-cycle `wb_en` to x7=32'hcafe_f00d and accept of `add` reading rs1=x7, x7 previously 0 → `op_a`=32'hcafe_f00d with `OPERAND_BYPASS_EN`, 0 without. With the macro, a writeback to x7 while held FULL updates `op_a`.
- Assert `rst` while FULL and `wb_en`=1 → next cycle `out_valid`=0, x-register reads all 0, and the write is discarded.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared constants and helpers for the operand-fetch stage.
//   - RV32I opcode and funct3 encodings (OPCODE_*, FUNCT3_*)
//   - instruction field positions for opcode, rd, rs1 and rs2
//   - output-stage state encoding and op_a source encoding
//   - small decode helpers used by operand_fetch
package operand_fetch_pkg;

  // RV32I major opcodes
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  // funct3 encodings for the integer ALU group
  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  // Instruction field positions
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;

  // One-entry output stage: EMPTY means out_valid=0, FULL means out_valid=1
  typedef enum logic {
    OF_EMPTY = 1'b0,
    OF_FULL  = 1'b1
  } of_state_e;

  typedef enum logic [1:0] {
    SRC_RS1  = 2'd0,
    SRC_PC   = 2'd1,
    SRC_ZERO = 2'd2
  } op_a_src_e;

  function automatic op_a_src_e op_a_src(input logic [6:0] opcode);
    op_a_src_e src;
    case (opcode)
      OPCODE_AUIPC, OPCODE_JAL, OPCODE_BRANCH: src = SRC_PC;
      OPCODE_LUI:                              src = SRC_ZERO;
      default:                                 src = SRC_RS1;
    endcase
    return src;
  endfunction

  function automatic logic [4:0] get_rs1(input logic [31:0] instr);
    return instr[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic [4:0] get_rs2(input logic [31:0] instr);
    return instr[RS2_MSB:RS2_LSB];
  endfunction

  function automatic logic [6:0] get_opcode(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/operand_fetch_register_file.sv
// operand_fetch_register_file: integer register file x1..x31 owned by the
// operand-fetch stage. x0 is not stored and always reads 0.
// Ports:
//   clk, rst         clock, synchronous active-high clear of all registers
//   rs1_addr_i/_o    read port A index / combinational data
//   rs2_addr_i/_o    read port B index / combinational data
//   we_i, wr_addr_i, wr_data_i  single synchronous write port (index 0 ignored)
// A read of the register being written in the same cycle returns the old value.
module operand_fetch_register_file #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            we_i,
  input  logic [4:0]      wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i
);

  logic [XLEN-1:0] regs_q [1:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset wins over a write issued in the same cycle.
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wr_addr_i != 5'd0)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rs1_data_o = (rs1_addr_i == 5'd0) ? '0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? '0 : regs_q[rs2_addr_i];

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: pipeline stage feeding the ALU. Reads rs1/rs2 from the local
// register file and presents instruction, pc, op_a, op_b through a one-entry
// registered output stage.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             upstream handshake, in_instruction/in_pc payload
//   out_valid/out_ready           downstream handshake
//   instruction, pc, op_a, op_b   registered outputs to the ALU
//   wb_en, wb_rd, wb_data         register-file write port
//   dbg_state_o                   current output-stage state (EMPTY/FULL)
// Configuration: define OPERAND_BYPASS_EN to forward writeback data into the
// operands, both on accept and while the output entry is held.
//
// Handshake: a transfer happens on an edge where valid && ready are both 1.
// in_ready = !out_valid || out_ready, so a full stage accepts a new
// instruction in the same cycle its current one is consumed (no bubble).
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_PC_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output of_state_e       dbg_state_o
);

  of_state_e       state_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] op_a_q;
  logic [XLEN-1:0] op_b_q;

  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_rdata;
  logic [XLEN-1:0] rs2_rdata;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] op_a_d;
  op_a_src_e       a_src;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            accept;
  logic            consume;

  assign rs1_addr = get_rs1(in_instruction);
  assign rs2_addr = get_rs2(in_instruction);
  assign a_src    = op_a_src(get_opcode(in_instruction));

  operand_fetch_register_file #(
    .XLEN(XLEN)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_data_o (rs1_rdata),
    .rs2_data_o (rs2_rdata),
    .we_i       (wb_en),
    .wr_addr_i  (wb_rd),
    .wr_data_i  (wb_data)
  );

`ifdef OPERAND_BYPASS_EN
  // Indices and op_a source of the held entry, for forwarding while FULL.
  logic [4:0] rs1_q;
  logic [4:0] rs2_q;
  logic       a_rs1_q;

  assign rs1_hit = wb_en && (wb_rd != 5'd0) && (wb_rd == rs1_addr);
  assign rs2_hit = wb_en && (wb_rd != 5'd0) && (wb_rd == rs2_addr);
`else
  assign rs1_hit = 1'b0;
  assign rs2_hit = 1'b0;
`endif

  assign rs1_val = rs1_hit ? wb_data : rs1_rdata;
  assign rs2_val = rs2_hit ? wb_data : rs2_rdata;

  always_comb begin
    op_a_d = rs1_val;
    case (a_src)
      SRC_PC:   op_a_d = in_pc;
      SRC_ZERO: op_a_d = '0;
      default:  op_a_d = rs1_val;
    endcase
  end

  assign out_valid = (state_q == OF_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OF_EMPTY;
      instr_q <= '0;
      pc_q    <= RESET_PC_VAL;
      op_a_q  <= '0;
      op_b_q  <= '0;
`ifdef OPERAND_BYPASS_EN
      rs1_q   <= '0;
      rs2_q   <= '0;
      a_rs1_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        OF_EMPTY: if (accept) state_q <= OF_FULL;
        OF_FULL:  if (consume && !accept) state_q <= OF_EMPTY;
        default:  state_q <= OF_EMPTY;
      endcase

      if (accept) begin
        instr_q <= in_instruction;
        pc_q    <= in_pc;
        op_a_q  <= op_a_d;
        op_b_q  <= rs2_val;
`ifdef OPERAND_BYPASS_EN
        rs1_q   <= rs1_addr;
        rs2_q   <= rs2_addr;
        a_rs1_q <= (a_src == SRC_RS1);
`endif
      end
`ifdef OPERAND_BYPASS_EN
      // Held entry tracks writebacks so it never carries a stale operand.
      else if (out_valid && !out_ready && wb_en && (wb_rd != 5'd0)) begin
        if (a_rs1_q && (wb_rd == rs1_q)) op_a_q <= wb_data;
        if (wb_rd == rs2_q)              op_b_q <= wb_data;
      end
`endif
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: self-checking bench for operand_fetch. Directed scenario
// tasks with inline checks, plus a reference scoreboard that predicts every
// output entry from a register-file model and the handshake rules.
module tb_operand_fetch;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam int          EW       = 4 * XLEN;

`ifdef OPERAND_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instruction;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            dbg_state;

  always #5 clk = ~clk;

  operand_fetch #(
    .XLEN         (XLEN),
    .RESET_PC_VAL (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instruction (in_instruction),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .instruction    (instruction),
    .pc             (pc),
    .op_a           (op_a),
    .op_b           (op_b),
    .wb_en          (wb_en),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .dbg_state_o    (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [XLEN-1:0] model_regs [32];
  logic [EW-1:0]   exp_q[$];
  bit              sb_en = 1'b0;

  function automatic bit is_pc_src(input logic [31:0] ins);
    return (ins[6:0] == 7'h17) || (ins[6:0] == 7'h6f) || (ins[6:0] == 7'h63);
  endfunction

  function automatic logic [XLEN-1:0] read_model(input logic [4:0] idx);
    logic [XLEN-1:0] v;
    v = (idx == 5'd0) ? '0 : model_regs[idx];
    if (BYPASS && wb_en && (wb_rd != 5'd0) && (wb_rd == idx)) v = wb_data;
    return v;
  endfunction

  function automatic logic [EW-1:0] expect_entry(input logic [31:0] ins, input logic [XLEN-1:0] pcv);
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    b = read_model(ins[24:20]);
    if (is_pc_src(ins))           a = pcv;
    else if (ins[6:0] == 7'h37)   a = '0;
    else                          a = read_model(ins[19:15]);
    return {ins, pcv, a, b};
  endfunction

  // Scoreboard: compare at the falling edge, then advance the model to
  // what the next rising edge will do.
  always @(negedge clk) begin
    if (sb_en) begin
      logic          exp_valid;
      logic          acc;
      logic [EW-1:0] head;
      logic [31:0]   hins;
      exp_valid = (exp_q.size() > 0);
      n_checks++;
      if (out_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL sb_out_valid: got %b expected %b at %0t", out_valid, exp_valid, $time);
      end
      n_checks++;
      if (in_ready !== (!exp_valid || out_ready)) begin
        n_fail++;
        $display("FAIL sb_in_ready: got %b expected %b at %0t", in_ready, (!exp_valid || out_ready), $time);
      end
      if (exp_valid) begin
        n_checks++;
        if ({instruction, pc, op_a, op_b} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL sb_entry: got %h expected %h at %0t", {instruction, pc, op_a, op_b}, exp_q[0], $time);
        end
      end
      if (rst) begin
        exp_q.delete();
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
      end else begin
        acc = in_valid && (!exp_valid || out_ready);
        if (exp_valid && out_ready) begin
          void'(exp_q.pop_front());
        end else if (BYPASS && exp_valid && wb_en && (wb_rd != 5'd0)) begin
          head = exp_q[0];
          hins = head[EW-1 -: 32];
          if (!is_pc_src(hins) && (hins[6:0] != 7'h37) && (hins[19:15] == wb_rd))
            head[2*XLEN-1 -: XLEN] = wb_data;
          if (hins[24:20] == wb_rd) head[XLEN-1:0] = wb_data;
          exp_q[0] = head;
        end
        if (acc) exp_q.push_back(expect_entry(in_instruction, in_pc));
        if (wb_en && (wb_rd != 5'd0)) model_regs[wb_rd] = wb_data;
      end
    end
  end

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction
  function automatic logic [31:0] enc_bne(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b001, 5'b0, 7'h63};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [XLEN-1:0] pcv);
    int budget;
    budget = 0;
    in_valid = 1'b1;
    in_instruction = ins;
    in_pc = pcv;
    while (!in_ready && budget < 50) begin
      cyc();
      budget++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got %b expected 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [XLEN-1:0] data);
    wb_en = 1'b1;
    wb_rd = rd;
    wb_data = data;
    cyc();
    wb_en = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_instruction = '0; in_pc = '0;
    out_ready = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    cyc();
    cyc();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instruction: got %h expected 0", instruction); end
    n_checks++;
    if (pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
    n_checks++;
    if ({op_a, op_b} !== '0) begin n_fail++; $display("FAIL reset_ops: got %h/%h expected 0/0", op_a, op_b); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    sb_en = 1'b1;
  endtask

  task automatic test_basic();
    wb_write(5'd5, 32'h1234_5678);
    out_ready = 1'b1;
    send(enc_add(5'd1, 5'd5, 5'd0), 32'h0000_0040);
    n_checks++;
    if ({out_valid, op_a, op_b} !== {1'b1, 32'h1234_5678, 32'h0}) begin
      n_fail++;
      $display("FAIL basic_add: got v=%b a=%h b=%h expected v=1 a=12345678 b=0", out_valid, op_a, op_b);
    end
  endtask

  task automatic test_opsel();
    send(enc_u(20'h12345, 5'd2, 7'h17), 32'h0000_0100);
    n_checks++;
    if (op_a !== 32'h0000_0100) begin n_fail++; $display("FAIL opsel_auipc: got %h expected 00000100", op_a); end
    send(enc_u(20'hfffff, 5'd2, 7'h37), 32'h0000_0104);
    n_checks++;
    if (op_a !== 32'h0) begin n_fail++; $display("FAIL opsel_lui: got %h expected 0", op_a); end
    send(enc_u(20'h0, 5'd1, 7'h6f), 32'h0000_0200);
    n_checks++;
    if (op_a !== 32'h0000_0200) begin n_fail++; $display("FAIL opsel_jal: got %h expected 00000200", op_a); end
    send(enc_bne(5'd0, 5'd5), 32'h0000_0300);
    n_checks++;
    if ({op_a, op_b} !== {32'h0000_0300, 32'h1234_5678}) begin
      n_fail++; $display("FAIL opsel_branch: got %h/%h expected 00000300/12345678", op_a, op_b);
    end
    send(enc_addi(5'd3, 5'd5, 12'h7ff), 32'h0000_0304);
    n_checks++;
    if (op_a !== 32'h1234_5678) begin n_fail++; $display("FAIL opsel_addi: got %h expected 12345678", op_a); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ins_a;
    logic [31:0] ins_b;
    ins_a = enc_add(5'd1, 5'd5, 5'd5);
    ins_b = enc_add(5'd2, 5'd0, 5'd5);
    drain();
    out_ready = 1'b0;
    send(ins_a, 32'h0000_0500);
    in_valid = 1'b1;
    in_instruction = ins_b;
    in_pc = 32'h0000_0504;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({in_ready, instruction, pc, op_a, op_b} !== {1'b0, ins_a, 32'h0000_0500, 32'h1234_5678, 32'h1234_5678}) begin
        n_fail++;
        $display("FAIL hold_stable: got rdy=%b ins=%h pc=%h a=%h b=%h", in_ready, instruction, pc, op_a, op_b);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, instruction, pc, op_a, op_b} !== {1'b1, ins_b, 32'h0000_0504, 32'h0, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL release_next: got v=%b ins=%h pc=%h expected ins=%h pc=00000504", out_valid, instruction, pc, ins_b);
    end
    drain();
  endtask

  task automatic test_x0();
    wb_write(5'd0, 32'hdead_beef);
    send(enc_add(5'd2, 5'd0, 5'd0), 32'h0000_0580);
    n_checks++;
    if ({op_a, op_b} !== 64'h0) begin n_fail++; $display("FAIL x0_read: got %h/%h expected 0/0", op_a, op_b); end
  endtask

  task automatic test_same_cycle();
    logic [XLEN-1:0] exp_a;
    drain();
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hcafe_f00d;
    send(enc_add(5'd3, 5'd7, 5'd0), 32'h0000_0600);
    wb_en = 1'b0;
    exp_a = BYPASS ? 32'hcafe_f00d : 32'h0;
    n_checks++;
    if (op_a !== exp_a) begin n_fail++; $display("FAIL same_cycle_wb: got %h expected %h", op_a, exp_a); end
    drain();
    // Held entry sees later writebacks only with forwarding.
    out_ready = 1'b0;
    send(enc_add(5'd4, 5'd7, 5'd6), 32'h0000_0700);
    wb_write(5'd7, 32'h1111_2222);
    exp_a = BYPASS ? 32'h1111_2222 : 32'hcafe_f00d;
    n_checks++;
    if (op_a !== exp_a) begin n_fail++; $display("FAIL held_fwd_a: got %h expected %h", op_a, exp_a); end
    wb_write(5'd6, 32'h3333_4444);
    n_checks++;
    if (op_b !== (BYPASS ? 32'h3333_4444 : 32'h0)) begin
      n_fail++; $display("FAIL held_fwd_b: got %h expected %h", op_b, (BYPASS ? 32'h3333_4444 : 32'h0));
    end
    drain();
    // lui whose rs1 field decodes as x7: op_a must stay 0.
    out_ready = 1'b0;
    send(enc_u(20'h00038, 5'd1, 7'h37), 32'h0000_0800);
    wb_write(5'd7, 32'h5555_6666);
    n_checks++;
    if (op_a !== 32'h0) begin n_fail++; $display("FAIL held_lui_no_fwd: got %h expected 0", op_a); end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_instruction = enc_add(5'(i + 1), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      in_pc = 32'h0000_0900 + 32'(4 * i);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
      cyc();
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_no_bubble: got %b expected 1", out_valid); end
    end
    drain();
  endtask

  task automatic test_random();
    logic [6:0] opcs [5];
    opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h17; opcs[3] = 7'h37; opcs[4] = 7'h63;
    for (int i = 0; i < 80; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_instruction = {$urandom()} & 32'hffff_ff80;
      in_instruction[6:0] = opcs[$urandom_range(0, 4)];
      in_pc = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en = 1'($urandom_range(0, 1));
      wb_rd = 5'($urandom_range(0, 31));
      wb_data = $urandom();
      cyc();
    end
    wb_en = 1'b0;
    drain();
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(enc_add(5'd1, 5'd5, 5'd5), 32'h0000_0a00);
    rst = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h9999_9999;
    in_valid = 1'b1; in_instruction = enc_add(5'd2, 5'd9, 5'd9); in_pc = 32'h0000_0a04;
    cyc();
    rst = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, instruction, pc, op_a, op_b} !== {1'b0, 1'b1, 32'h0, RESET_PC, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_reset_state: got v=%b rdy=%b ins=%h pc=%h a=%h b=%h", out_valid, in_ready, instruction, pc, op_a, op_b);
    end
    out_ready = 1'b1;
    send(enc_add(5'd1, 5'd9, 5'd5), 32'h0000_0b00);
    n_checks++;
    if ({op_a, op_b} !== 64'h0) begin n_fail++; $display("FAIL mid_reset_regs: got %h/%h expected 0/0", op_a, op_b); end
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_opsel();
    test_backpressure();
    test_x0();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
